// File: rtl/id_ex_pkg.sv
// Shared types and defaults for the ID/EX pipeline stage.
package id_ex_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          ILEN_DEF      = 32;
    // addi x0,x0,0 -- the canonical RISC-V NOP presented for bubbles
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Stage occupancy doubles as the skid-buffer state
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // Payload layout carried through the stage (MSB first: pc ... instr)
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] rs1;
        logic [XLEN_DEF-1:0] rs2;
        logic [XLEN_DEF-1:0] imm;
        logic [ILEN_DEF-1:0] instr;
    } id_ex_payload_t;

    // Flat payload width for a given operand/instruction width
    function automatic int payload_w(input int xlen, input int ilen);
        return 4 * xlen + ilen;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid stage with flush and a bubble fill value.
// Outputs come only from the main register; in_ready is registered.
module pipe_skid_buffer
    import id_ex_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] bubble,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    occ_state_t   state_p1;
    occ_state_t   state_nxt;
    logic         rdy_p1;
    logic         rdy_nxt;
    logic [W-1:0] main_p1;
    logic [W-1:0] skid_p1;
    logic [W-1:0] main_nxt;
    logic [W-1:0] skid_nxt;
    logic         accept;
    logic         emit;

    assign accept = in_valid & rdy_p1;
    assign emit   = (state_p1 != EMPTY) & out_ready;

    // Next state and register loads; flush empties both entries and drops the input
    always_comb begin
        state_nxt = state_p1;
        main_nxt  = main_p1;
        skid_nxt  = skid_p1;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = bubble;
            skid_nxt  = bubble;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state_nxt = TWO;
                        skid_nxt  = in_data;
                    end else if (accept && emit) begin
                        main_nxt  = in_data;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                        main_nxt  = bubble;
                    end
                end
                TWO: begin
                    // in_ready is low here, so nothing can be accepted
                    if (emit) begin
                        state_nxt = ONE;
                        main_nxt  = skid_p1;
                        skid_nxt  = bubble;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = bubble;
                    skid_nxt  = bubble;
                end
            endcase
        end
        rdy_nxt = (state_nxt != TWO);
    end

    // Control registers: occupancy state and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= EMPTY;
            rdy_p1   <= 1'b1;
        end else begin
            state_p1 <= state_nxt;
            rdy_p1   <= rdy_nxt;
        end
    end

    // Data registers: no reset, consumers qualify them with out_valid
    always_ff @(posedge clk) begin
        main_p1 <= main_nxt;
        skid_p1 <= skid_nxt;
    end

    assign in_ready  = rdy_p1;
    assign out_valid = (state_p1 != EMPTY);
    assign out_data  = main_p1;
    assign occupancy = state_p1;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline stage: skid-buffered payload from decode to execute with
// stall, flush and NOP bubble presentation plus rd/funct3/instr[30] extraction.
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              ILEN      = ILEN_DEF,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF[ILEN-1:0]
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] read_data_1_in,
    input  logic [XLEN-1:0] read_data_2_in,
    input  logic [XLEN-1:0] immediate_gen_in,
    input  logic [ILEN-1:0] instruction_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] read_data_1_out,
    output logic [XLEN-1:0] read_data_2_out,
    output logic [XLEN-1:0] immediate_gen_out,
    output logic [ILEN-1:0] instruction_out,
    output logic [4:0]      instruction_11_7_out,
    output logic [2:0]      instruction_14_12_out,
    output logic            instruction_30_out,
    output logic [1:0]      occupancy
);

    localparam int W       = payload_w(XLEN, ILEN);
    localparam int IMM_LSB = ILEN;
    localparam int RS2_LSB = ILEN + XLEN;
    localparam int RS1_LSB = ILEN + 2 * XLEN;
    localparam int PC_LSB  = ILEN + 3 * XLEN;

    logic [W-1:0]    payload_p0;
    logic [W-1:0]    bubble;
    logic [W-1:0]    main_p1;
    logic            vld_p1;
    logic [ILEN-1:0] instr_p1;

    assign payload_p0 = {pc_in, read_data_1_in, read_data_2_in, immediate_gen_in, instruction_in};
    assign bubble     = {{(4 * XLEN){1'b0}}, NOP_INSTR};

    // ---- ID -> EX register boundary ----
    pipe_skid_buffer #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_p0),
        .bubble    (bubble),
        .out_valid (vld_p1),
        .out_ready (out_ready),
        .out_data  (main_p1),
        .occupancy (occupancy)
    );

    // Empty stage always presents a NOP with zero operands, even straight out of reset
    assign out_valid         = vld_p1;
    assign pc_out            = vld_p1 ? main_p1[PC_LSB  +: XLEN] : '0;
    assign read_data_1_out   = vld_p1 ? main_p1[RS1_LSB +: XLEN] : '0;
    assign read_data_2_out   = vld_p1 ? main_p1[RS2_LSB +: XLEN] : '0;
    assign immediate_gen_out = vld_p1 ? main_p1[IMM_LSB +: XLEN] : '0;
    assign instr_p1          = vld_p1 ? main_p1[ILEN-1:0] : NOP_INSTR;

    assign instruction_out       = instr_p1;
    assign instruction_11_7_out  = instr_p1[11:7];
    assign instruction_14_12_out = instr_p1[14:12];
    assign instruction_30_out    = instr_p1[30];

endmodule
